conv_window_feeder: RTL
=======================

CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 Parameter IMG_W, default 8: pixels per image row; legal range 3..255.
REQ-002 Parameter IMG_H, default 8: rows per frame; legal range 3..255.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low.
REQ-005 pix_in  input  8  unsigned pixel, raster order.
REQ-006 pix_valid  input  1  pix_in is valid.
REQ-007 pix_ready  output  1  feeder accepts pix_in this cycle.
REQ-008 k_in  input  8  kernel coefficient, serial order k11..k33.
REQ-009 k_load  input  1  k_in is valid.
REQ-010 win_x  output  72  3x3 window; x11 at [7:0] through x33 at [71:64], row-major.
REQ-011 kern_k  output  72  loaded kernel, same packing as win_x.
REQ-012 conv_start  output  1  start request to the convolution engine.
REQ-013 conv_done  input  1  engine done flag.
REQ-014 conv_result  input  20  engine sum of products.
REQ-015 res_out  output  20  captured window result.
REQ-016 res_valid  output  1  res_out is valid.
REQ-017 res_ready  input  1  consumer accepts res_out.
REQ-018 frame_done  output  1  one-cycle pulse after the last result of a frame is accepted.

Function
REQ-019 A pixel transfer occurs only when pix_valid and pix_ready are both high in the same cycle.
REQ-020 Pixel storage: two IMG_W-deep line buffers plus a 3x3 shift window; column counter wraps IMG_W-1 to 0 and increments the row counter.
REQ-021 States: FILL, START, WAIT, CAPTURE, OUT.
- In FILL, pix_ready is high.
- In every other state, pix_ready is low.
REQ-022 FILL to START: on the transfer that completes a window, i.e. column >= 2 and row >= 2 after the shift.
REQ-023 In START, WAIT and CAPTURE, win_x is frozen and conv_start is high.
REQ-024 START to WAIT: when conv_done is sampled high.
REQ-025 WAIT to CAPTURE: after exactly one further cycle; this covers the engine's second register stage.
REQ-026 In CAPTURE, conv_result is registered into res_out and conv_start is driven low in the next cycle; then go to OUT.
REQ-027 In OUT, res_valid is high and res_out is held stable until res_ready is high.
- On acceptance, go to FILL.
- If that result was the frame's last window, go to FILL with the counters cleared and pulse frame_done.
REQ-028 Each frame yields (IMG_W-2)*(IMG_H-2) results, in raster order.
REQ-029 Kernel loading:
- k_load is accepted only in FILL when no window has yet been issued in the current frame.
- At any other time k_load is ignored.
- Each accepted k_load shifts one coefficient into kern_k.
- After 9 loads the kernel is complete; further loads wrap and restart at k11.
REQ-030 Widths: res_out = conv_result, zero-extended nothing, bit-exact; no saturation.
REQ-031 If pix_valid and k_load are high in the same cycle, both are accepted independently.

Reset
REQ-032 While reset is low: state = FILL; counters, line buffers, win_x, kern_k and res_out = 0; conv_start, res_valid and frame_done = 0; pix_ready = 0.
REQ-033 pix_ready goes high on the first clk edge after reset is released.
REQ-034 Reset asserted mid-window aborts immediately with no partial output; the frame restarts from pixel 0.

Configuration
REQ-035 Macro FEEDER_TIMEOUT_EN, when defined, adds:
- a 4-bit watchdog counting cycles spent in START;
- after 16 cycles without conv_done, conv_start drops, output err (1 bit, sticky until reset) sets, and a result of 0 is delivered through OUT.
REQ-036 Without FEEDER_TIMEOUT_EN: no err port; START waits indefinitely.

Verification
REQ-037 IMG_W=IMG_H=4, kernel all 1, 16 pixels of 1, engine model with two-stage latency, res_ready=1 -> 4 results, each 9, then one frame_done pulse.
REQ-038 Kernel all 255, pixels all 255 -> every res_out = 585225 (0x8EE09); no truncation.
REQ-039 res_ready held low for 5 cycles in OUT -> res_out and res_valid stable, pix_ready=0, no conv_start.
REQ-040 k_load pulsed with k_in=7 after the first window has been issued -> kern_k unchanged and subsequent results unchanged.
REQ-041 reset driven low during WAIT -> all outputs 0 asynchronously; after release, a full frame produces the correct 4 results.
REQ-042 FEEDER_TIMEOUT_EN defined, conv_done tied 0 -> after 16 START cycles err=1, res_out=0 with res_valid=1, and FILL resumes.

Source files
------------

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to 3x3 window feeder with serial kernel load and a start/done handshake to a convolution engine.
// Optional FEEDER_TIMEOUT_EN adds a START watchdog and a sticky err output.
module conv_window_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  k_in,
  input  logic        k_load,
  output logic [71:0] win_x,
  output logic [71:0] kern_k,
  output logic        conv_start,
  input  logic        conv_done,
  input  logic [19:0] conv_result,
  output logic [19:0] res_out,
  output logic        res_valid,
  input  logic        res_ready,
`ifdef FEEDER_TIMEOUT_EN
  output logic        err,
`endif
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [2:0] FILL    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] OUT     = 3'd4;

  logic [2:0]    state_r, state_s;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [7:0]    lb0_r [IMG_W];
  logic [7:0]    lb1_r [IMG_W];
  logic [71:0]   win_r, kern_r;
  logic [3:0]    kcnt_r;
  logic          issued_r, last_r;
  logic [19:0]   res_r;
  logic          pix_ready_r, conv_start_r, res_valid_r, frame_done_r;
  logic          xfer_s, kacc_s, accept_s, win_done_s, last_win_s, tmo_s;

  assign xfer_s     = pix_valid & pix_ready_r;
  assign win_done_s = xfer_s && (col_r >= CW'(2)) && (row_r >= RW'(2));
  assign last_win_s = (col_r == CW'(IMG_W - 1)) && (row_r == RW'(IMG_H - 1));
  assign accept_s   = (state_r == OUT) && res_ready;
  assign kacc_s     = k_load && (state_r == FILL) && !issued_r;

`ifdef FEEDER_TIMEOUT_EN
  logic [3:0] wd_r;
  logic       err_r;
  assign tmo_s = (state_r == START) && !conv_done && (wd_r == 4'hF);
  assign err   = err_r;

  // Watchdog over cycles spent in START; err stays set until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r  <= 4'd0;
      err_r <= 1'b0;
    end else begin
      wd_r  <= (state_r == START) ? wd_r + 4'd1 : 4'd0;
      err_r <= err_r | tmo_s;
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FILL:    if (win_done_s) state_s = START; else state_s = FILL;
      START: begin
        if (conv_done)  state_s = WAIT;
        else if (tmo_s) state_s = OUT;
        else            state_s = START;
      end
      WAIT:    state_s = CAPTURE;
      CAPTURE: state_s = OUT;
      OUT:     if (res_ready) state_s = FILL; else state_s = OUT;
      default: state_s = FILL;
    endcase
  end

  // Line buffers, shift window and raster position; the window only moves in FILL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r <= '0;
      row_r <= '0;
      win_r <= 72'd0;
      for (int i = 0; i < IMG_W; i++) begin
        lb0_r[i] <= 8'd0;
        lb1_r[i] <= 8'd0;
      end
    end else if (xfer_s) begin
      lb1_r[col_r] <= lb0_r[col_r];
      lb0_r[col_r] <= pix_in;
      win_r <= {pix_in, win_r[71:56], lb0_r[col_r], win_r[47:32], lb1_r[col_r], win_r[23:8]};
      if (col_r == CW'(IMG_W - 1)) begin
        col_r <= '0;
        row_r <= row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end else if (accept_s && last_r) begin
      col_r <= '0;
      row_r <= '0;
    end
  end

  // Control state, kernel capture, result register and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= FILL;
      kern_r       <= 72'd0;
      kcnt_r       <= 4'd0;
      issued_r     <= 1'b0;
      last_r       <= 1'b0;
      res_r        <= 20'd0;
      pix_ready_r  <= 1'b0;
      conv_start_r <= 1'b0;
      res_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (kacc_s) begin
        kern_r[{kcnt_r, 3'b000} +: 8] <= k_in;
        kcnt_r <= (kcnt_r == 4'd8) ? 4'd0 : kcnt_r + 4'd1;
      end
      if (win_done_s) begin
        issued_r <= 1'b1;
        last_r   <= last_win_s;
      end else if (accept_s && last_r) begin
        issued_r <= 1'b0;
        last_r   <= 1'b0;
      end
      if (state_r == CAPTURE) res_r <= conv_result;
      else if (tmo_s)         res_r <= 20'd0;
      pix_ready_r  <= (state_s == FILL);
      conv_start_r <= (state_s == START) || (state_s == WAIT) || (state_s == CAPTURE);
      res_valid_r  <= (state_s == OUT);
      frame_done_r <= accept_s && last_r;
    end
  end

  assign pix_ready  = pix_ready_r;
  assign win_x      = win_r;
  assign kern_k     = kern_r;
  assign conv_start = conv_start_r;
  assign res_out    = res_r;
  assign res_valid  = res_valid_r;
  assign frame_done = frame_done_r;

endmodule
